ccff_bitstream_loader: RTL and testbench

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

---
 rtl/ccff_loader_pkg.sv | 14 +
 rtl/ccff_crc16_serial.sv | 28 ++
 rtl/ccff_bitstream_loader.sv | 133 +++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16/CCITT-FALSE (poly 0x1021, MSB-first, no reflection, no final XOR).
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        in_bit,
  input  logic        init,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ in_bit;

  // One CRC step per enabled bit; init restarts the checksum and wins over enable.
  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams configuration bytes MSB-first into a serial CLB configuration chain,
// gating the chain clock so exactly CHAIN_LEN bits are shifted per load, and
// checksums the bits that fall out of the chain tail.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64
) (
  input  logic        prog_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        ccff_head,
  input  logic        ccff_tail,
  output logic        shift_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] tail_crc
);

  localparam int               CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ccff_state_t      state;
  ccff_state_t      state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic             done_q;
  logic             last_shift;
  logic             last_of_byte;
  logic             begin_load;
  logic             accept;

  assign last_shift   = (bit_cnt == CNT_LAST);
  assign last_of_byte = (bit_idx == 3'd7);
  assign begin_load   = start && ((state == IDLE) || (state == DONE));
  assign accept       = cfg_valid && cfg_ready;
  assign ccff_head    = shift_en && shift_reg[7];
  assign done         = done_q;

  // State register.
  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the decoded handshake and chain-clock enable.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        busy      = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (last_shift) begin
          state_next = DONE;
        end else if (last_of_byte) begin
          cfg_ready = 1'b1;
          if (!cfg_valid) begin
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte capture, MSB-first shifting and the saturating count of bits sent.
  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (begin_load) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      if (shift_en && (bit_cnt != CNT_FULL)) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
      if (accept) begin
        shift_reg <= cfg_data;
        bit_idx   <= 3'd0;
      end else if (shift_en) begin
        shift_reg <= {shift_reg[6:0], 1'b0};
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end

  // Sticky completion flag, set after the final chain bit and cleared by a new start.
  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else if (begin_load) begin
      done_q <= 1'b0;
    end else if (shift_en && last_shift) begin
      done_q <= 1'b1;
    end
  end

  ccff_crc16_serial u_tail_crc (
    .prog_clk (prog_clk),
    .reset_n  (reset_n),
    .enable   (shift_en),
    .in_bit   (ccff_tail),
    .init     (begin_load),
    .crc      (tail_crc)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Self-checking bench: three loaders (chain lengths 64, 13, 72) each drive a
// modelled external chain; a queue-style reference model predicts the outputs.
module tb_ccff_bitstream_loader;

  logic        prog_clk = 1'b0;
  logic        reset_n;
  logic        start     [3];
  logic [7:0]  cfg_data  [3];
  logic        cfg_valid [3];
  logic        cfg_ready [3];
  logic        ccff_head [3];
  logic        ccff_tail [3];
  logic        shift_en  [3];
  logic        busy      [3];
  logic        done      [3];
  logic [15:0] tail_crc  [3];

  logic [63:0] chain0 = '0;
  logic [12:0] chain1 = '0;
  logic [71:0] chain2 = '0;

  int tests = 0;
  int fails = 0;

  bit          m_loading [3];
  bit          m_done    [3];
  int          m_shifts  [3];
  int          m_wr      [3];
  int          m_rd      [3];
  logic [15:0] m_crc     [3];
  bit          m_stream  [3][128];

  logic [7:0]  bytes_q [16];
  int          shifts_seen;
  int          stall_cycles;
  int          ready_after2;
  int          max_run;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(64)) dut0 (
    .prog_clk(prog_clk), .reset_n(reset_n), .start(start[0]), .cfg_data(cfg_data[0]),
    .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]), .ccff_head(ccff_head[0]),
    .ccff_tail(ccff_tail[0]), .shift_en(shift_en[0]), .busy(busy[0]), .done(done[0]),
    .tail_crc(tail_crc[0])
  );

  ccff_bitstream_loader #(.CHAIN_LEN(13)) dut1 (
    .prog_clk(prog_clk), .reset_n(reset_n), .start(start[1]), .cfg_data(cfg_data[1]),
    .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]), .ccff_head(ccff_head[1]),
    .ccff_tail(ccff_tail[1]), .shift_en(shift_en[1]), .busy(busy[1]), .done(done[1]),
    .tail_crc(tail_crc[1])
  );

  ccff_bitstream_loader #(.CHAIN_LEN(72)) dut2 (
    .prog_clk(prog_clk), .reset_n(reset_n), .start(start[2]), .cfg_data(cfg_data[2]),
    .cfg_valid(cfg_valid[2]), .cfg_ready(cfg_ready[2]), .ccff_head(ccff_head[2]),
    .ccff_tail(ccff_tail[2]), .shift_en(shift_en[2]), .busy(busy[2]), .done(done[2]),
    .tail_crc(tail_crc[2])
  );

  assign ccff_tail[0] = chain0[63];
  assign ccff_tail[1] = chain1[12];
  assign ccff_tail[2] = chain2[71];

  // External configuration chains: advance only on gated clock edges.
  always @(posedge prog_clk) begin
    if (shift_en[0] === 1'b1) chain0 <= {chain0[62:0], ccff_head[0]};
    if (shift_en[1] === 1'b1) chain1 <= {chain1[11:0], ccff_head[1]};
    if (shift_en[2] === 1'b1) chain2 <= {chain2[70:0], ccff_head[2]};
  end

  function automatic int len_of(input int d);
    case (d)
      0:       return 64;
      1:       return 13;
      default: return 72;
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic bit exp_ready(input int d);
    int pend;
    pend = m_wr[d] - m_rd[d];
    return m_loading[d] && ((pend == 0) || ((pend == 1) && (m_shifts[d] + 1 < len_of(d))));
  endfunction

  function automatic bit exp_shift(input int d);
    return m_loading[d] && (m_wr[d] > m_rd[d]);
  endfunction

  function automatic bit exp_head(input int d);
    return exp_shift(d) ? m_stream[d][m_rd[d]] : 1'b0;
  endfunction

  function automatic logic [71:0] packed_bytes(input int n);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[63:0], bytes_q[i]};
    return r;
  endfunction

  task automatic check(input string name, input int d, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic check_output();
    for (int d = 0; d < 3; d++) begin
      check("cfg_ready", d, 72'(cfg_ready[d]), 72'(exp_ready(d)));
      check("shift_en",  d, 72'(shift_en[d]),  72'(exp_shift(d)));
      check("ccff_head", d, 72'(ccff_head[d]), 72'(exp_head(d)));
      check("busy",      d, 72'(busy[d]),      72'(m_loading[d]));
      check("done",      d, 72'(done[d]),      72'(m_done[d]));
      check("tail_crc",  d, 72'(tail_crc[d]),  72'(m_crc[d]));
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_loading[d] = 1'b0;
      m_done[d]    = 1'b0;
      m_shifts[d]  = 0;
      m_wr[d]      = 0;
      m_rd[d]      = 0;
      m_crc[d]     = 16'hFFFF;
    end
  endtask

  // Apply the inputs that the coming rising edge will see.
  task automatic advance_model();
    bit r;
    bit s;
    for (int d = 0; d < 3; d++) begin
      r = exp_ready(d);
      s = exp_shift(d);
      if (!m_loading[d]) begin
        if (start[d]) begin
          m_loading[d] = 1'b1;
          m_done[d]    = 1'b0;
          m_shifts[d]  = 0;
          m_wr[d]      = 0;
          m_rd[d]      = 0;
          m_crc[d]     = 16'hFFFF;
        end
      end else begin
        if (s) begin
          m_crc[d] = crc_step(m_crc[d], ccff_tail[d]);
          m_rd[d]++;
          m_shifts[d]++;
        end
        if (cfg_valid[d] && r) begin
          for (int b = 7; b >= 0; b--) begin
            if (m_wr[d] < len_of(d)) begin
              m_stream[d][m_wr[d]] = cfg_data[d][b];
              m_wr[d]++;
            end
          end
        end
        if (m_shifts[d] == len_of(d)) begin
          m_loading[d] = 1'b0;
          m_done[d]    = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    for (int d = 0; d < 3; d++) begin
      start[d]     = 1'b0;
      cfg_valid[d] = 1'b0;
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      check("rst_cfg_ready", d, 72'(cfg_ready[d]), 72'(0));
      check("rst_shift_en",  d, 72'(shift_en[d]),  72'(0));
      check("rst_ccff_head", d, 72'(ccff_head[d]), 72'(0));
      check("rst_busy",      d, 72'(busy[d]),      72'(0));
      check("rst_done",      d, 72'(done[d]),      72'(0));
      check("rst_tail_crc",  d, 72'(tail_crc[d]),  72'(16'hFFFF));
    end
    repeat (2) begin
      @(negedge prog_clk);
      check_output();
    end
    reset_n = 1'b1;
  endtask

  // One complete load on dut d: start pulse, then bytes from bytes_q with
  // optional withholding, random gaps, a stray start, or a mid-load reset.
  task automatic run_load(input int d, input int nbytes, input int hold_after, input int hold_len,
                          input int start_at, input int reset_at, input bit rnd);
    int  sent;
    int  held;
    int  run;
    bit  rdy;
    bit  finished;
    sent = 0; held = 0; run = 0; finished = 1'b0;
    shifts_seen = 0; stall_cycles = 0; ready_after2 = 0; max_run = 0;
    @(negedge prog_clk);
    check_output();
    start[d]     = 1'b1;
    cfg_valid[d] = 1'b0;
    advance_model();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge prog_clk);
      check_output();
      start[d] = 1'b0;
      if (shift_en[d]) begin
        shifts_seen++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        if (busy[d]) stall_cycles++;
      end
      if (sent >= 2 && cfg_ready[d]) ready_after2++;
      if (!m_loading[d]) begin
        finished = 1'b1;
        break;
      end
      if (reset_at >= 0 && shifts_seen == reset_at) begin
        do_reset();
        return;
      end
      start[d]     = (shifts_seen == start_at);
      rdy          = exp_ready(d);
      cfg_valid[d] = 1'b0;
      cfg_data[d]  = 8'($urandom);
      if (sent < nbytes) begin
        if (!rdy && rnd) begin
          cfg_valid[d] = 1'($urandom_range(0, 1));
        end else if (sent == hold_after && rdy && held < hold_len) begin
          held++;
        end else if (rnd && $urandom_range(0, 3) == 0) begin
          cfg_valid[d] = 1'b0;
        end else begin
          cfg_valid[d] = 1'b1;
          cfg_data[d]  = bytes_q[sent];
        end
      end
      if (cfg_valid[d] && rdy) sent++;
      advance_model();
    end
    start[d]     = 1'b0;
    cfg_valid[d] = 1'b0;
    check("load_finished", d, 72'(finished), 72'(1));
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d]     = 1'b0;
      cfg_valid[d] = 1'b0;
      cfg_data[d]  = 8'h00;
    end
    reset_n = 1'b1;
    do_reset();

    // Back-to-back 0xA5 bytes.
    for (int i = 0; i < 8; i++) bytes_q[i] = 8'hA5;
    run_load(0, 8, -1, 0, -1, -1, 1'b0);
    check("a5_shifts",  0, 72'(shifts_seen),  72'(64));
    check("a5_run",     0, 72'(max_run),      72'(64));
    check("a5_stalls",  0, 72'(stall_cycles), 72'(1));
    check("a5_done",    0, 72'(done[0]),      72'(1));
    check("a5_chain",   0, 72'(chain0),       72'({8{8'hA5}}));

    // Third byte withheld for three cycles.
    run_load(0, 8, 2, 3, -1, -1, 1'b0);
    check("gap_shifts", 0, 72'(shifts_seen),  72'(64));
    check("gap_stalls", 0, 72'(stall_cycles), 72'(4));
    check("gap_chain",  0, 72'(chain0),       72'({8{8'hA5}}));

    // Stray start mid-load, then restart from DONE with random traffic.
    for (int i = 0; i < 8; i++) bytes_q[i] = 8'($urandom);
    run_load(0, 8, -1, 0, 10, -1, 1'b0);
    check("stray_shifts", 0, 72'(shifts_seen), 72'(64));
    check("stray_done",   0, 72'(done[0]),     72'(1));
    check("stray_chain",  0, 72'(chain0),      packed_bytes(8));
    for (int i = 0; i < 8; i++) bytes_q[i] = 8'($urandom);
    run_load(0, 8, -1, 0, -1, -1, 1'b1);
    check("restart_chain", 0, 72'(chain0), packed_bytes(8));

    // Reset after 30 shifts, then a complete load.
    run_load(0, 8, -1, 0, -1, 30, 1'b0);
    for (int i = 0; i < 8; i++) bytes_q[i] = 8'($urandom);
    run_load(0, 8, -1, 0, -1, -1, 1'b0);
    check("post_rst_shifts", 0, 72'(shifts_seen), 72'(64));
    check("post_rst_chain",  0, 72'(chain0),      packed_bytes(8));

    // Short chain with a partially used final byte.
    bytes_q[0] = 8'hFF;
    bytes_q[1] = 8'hB7;
    run_load(1, 2, -1, 0, -1, -1, 1'b0);
    check("c13_shifts", 1, 72'(shifts_seen),  72'(13));
    check("c13_chain",  1, 72'(chain1),       72'(13'b1111111110110));
    check("c13_ready",  1, 72'(ready_after2), 72'(0));
    check("c13_done",   1, 72'(done[1]),      72'(1));
    for (int k = 0; k < 4; k++) begin
      bytes_q[0] = 8'($urandom);
      bytes_q[1] = 8'($urandom);
      run_load(1, 2, -1, 0, -1, -1, 1'b1);
      check("c13_rnd_chain", 1, 72'(chain1), packed_bytes(2) >> 3);
    end

    // Tail CRC of a chain preloaded with "123456789".
    bytes_q[0] = 8'h31; bytes_q[1] = 8'h32; bytes_q[2] = 8'h33;
    bytes_q[3] = 8'h34; bytes_q[4] = 8'h35; bytes_q[5] = 8'h36;
    bytes_q[6] = 8'h37; bytes_q[7] = 8'h38; bytes_q[8] = 8'h39;
    run_load(2, 9, -1, 0, -1, -1, 1'b0);
    check("c72_preload", 2, chain2, packed_bytes(9));
    for (int i = 0; i < 9; i++) bytes_q[i] = 8'($urandom);
    run_load(2, 9, -1, 0, -1, -1, 1'b1);
    check("c72_crc",    2, 72'(tail_crc[2]), 72'(16'h29B1));
    check("c72_chain",  2, chain2,           packed_bytes(9));
    check("c72_shifts", 2, 72'(shifts_seen), 72'(72));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
